// File: rtl/fir_ntap_csa.sv
// fir_ntap_csa: N-tap moving-sum FIR with all coefficients equal to 1.
// The window sum is produced by a fully registered adder tree whose nodes
// are carry-skip adders. Inputs are valid-qualified. A fill counter tags
// only full windows as valid, and flush clears the window and all
// in-flight tags.
// Optional build macro: AVG_MODE_EN. When defined, s is the truncating
// mean (window sum >> log2(TAPS)). The shift is applied before the output
// register, so it adds no latency.

// Carry-skip adder with carry-in fixed at 0. The result is one bit wider
// than the operands. The last block is shorter when BLK does not divide W.
module fir_ntap_csa_cska #(
  parameter int W   = 16,
  parameter int BLK = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W:0]   sum
);
  localparam int NB = (W + BLK - 1) / BLK;

  logic [NB:0] blk_c;
  assign blk_c[0] = 1'b0;

  genvar gi, gj;
  for (gi = 0; gi < NB; gi++) begin : blk
    localparam int LO = gi * BLK;
    localparam int BW = ((W - LO) < BLK) ? (W - LO) : BLK;
    logic [BW-1:0] p;
    logic [BW-1:0] g;
    logic [BW:0]   rc;
    assign p     = x[LO +: BW] ^ y[LO +: BW];
    assign g     = x[LO +: BW] & y[LO +: BW];
    assign rc[0] = blk_c[gi];
    // Ripple carry inside the block.
    for (gj = 0; gj < BW; gj++) begin : bit_g
      assign rc[gj+1] = g[gj] | (p[gj] & rc[gj]);
    end
    assign sum[LO +: BW] = p ^ rc[BW-1:0];
    // If the whole block propagates, the block carry-in skips straight to the next block.
    assign blk_c[gi+1] = (&p) ? blk_c[gi] : rc[BW];
  end

  assign sum[W] = blk_c[NB];
endmodule

module fir_ntap_csa #(
  parameter int w        = 16,
  parameter int TAPS     = 4,
  parameter int SKIP_BLK = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [w-1:0]                a,
  input  logic                        a_valid,
  input  logic                        flush,
  output logic [w+$clog2(TAPS)-1:0]   s,
  output logic                        s_valid
);
  localparam int L  = $clog2(TAPS);
  localparam int OW = w + L;
  localparam int FW = $clog2(TAPS + 1);

  logic [TAPS*w-1:0] taps_q;   // tap 0 (newest) in the low bits
  logic [FW-1:0]     fill_q;
  logic [FW-1:0]     fill_base;
  logic [FW-1:0]     fill_next;
  logic              tag_next;
  logic [L:0]        vld_q;    // vld_q[k] travels with tree level k (0 = delay line)

  // Next fill count and full-window tag for the sample accepted this cycle.
  always_comb begin
    fill_base = flush ? '0 : fill_q;
    fill_next = fill_base;
    if (a_valid && (fill_base != FW'(TAPS)))
      fill_next = fill_base + 1'b1;
    tag_next = a_valid && (fill_next == FW'(TAPS));
  end

  // Delay line, fill counter and valid-tag pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      taps_q <= '0;
      fill_q <= '0;
      vld_q  <= '0;
    end else begin
      if (flush)
        taps_q <= a_valid ? {{((TAPS-1)*w){1'b0}}, a} : '0;
      else if (a_valid)
        taps_q <= {taps_q[(TAPS-1)*w-1:0], a};
      fill_q <= fill_next;
      vld_q  <= flush ? {{L{1'b0}}, tag_next} : {vld_q[L-1:0], tag_next};
    end
  end

  genvar gi, gj;
  for (gi = 1; gi <= L; gi++) begin : lvl
    localparam int IW = w + gi - 1;     // operand width at this level
    localparam int NN = TAPS >> gi;     // node count at this level
    logic [2*NN*IW-1:0]     in_c;
    logic [NN*(IW+1)-1:0]   sum_c;
    logic [NN*(IW+1)-1:0]   data_q;

    if (gi == 1) begin : src_taps
      assign in_c = taps_q;
    end else begin : src_prev
      assign in_c = lvl[gi-1].data_q;
    end

    for (gj = 0; gj < NN; gj++) begin : node
      fir_ntap_csa_cska #(.W(IW), .BLK(SKIP_BLK)) u_add (
        .x   (in_c[(2*gj)*IW +: IW]),
        .y   (in_c[(2*gj+1)*IW +: IW]),
        .sum (sum_c[gj*(IW+1) +: IW+1])
      );
    end

    if (gi < L) begin : mid
      // Intermediate tree register: free-running, its validity is carried by vld_q.
      always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else       data_q <= sum_c;
      end
    end else begin : last
      logic [NN*(IW+1)-1:0] out_val;
`ifdef AVG_MODE_EN
      assign out_val = sum_c >> L;
`else
      assign out_val = sum_c;
`endif
      // Output register: loads only full-window results, otherwise holds.
      always_ff @(posedge clk) begin
        if (reset)                     data_q <= '0;
        else if (vld_q[L-1] && !flush) data_q <= out_val;
      end
    end
  end

  assign s       = lvl[L].data_q[OW-1:0];
  assign s_valid = vld_q[L];
endmodule
